// File: rtl/oc_retry_ctrl.sv
// Overcurrent supervisor: synchronizes and debounces two comparator trips, gates the
// H-bridge enables, and sequences cooldown, bounded auto-retry and a sticky lockout.
module oc_retry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int COOLDOWN_CYCLES = 1000,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       resetBTN,
  input  logic       IA,
  input  logic       IB,
  input  logic       run_req,
  output logic       enA,
  output logic       enB,
  output logic       oc,
  output logic       lockout,
  output logic [1:0] fault_src,
  output logic [1:0] retry_cnt
);

  localparam int               DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_TRIP,
    S_COOLDOWN,
    S_LOCKOUT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_a, sync_b;
  logic [DB_W-1:0]   db_a, db_b;
  logic [CNT_W-1:0]  timer;
  logic [1:0]        trip_src;
  logic              conf_a, conf_b;
  logic [1:0]        retry_inc;

  assign conf_a    = (db_a == DB_MAX);
  assign conf_b    = (db_b == DB_MAX);
  assign retry_inc = retry_cnt + 2'd1;

  // Two-flop synchronizers feeding saturating debounce counters.
  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the sync chain.
  always_ff @(posedge clock) begin
    if (resetBTN) begin
      sync_a <= '0;
      sync_b <= '0;
      db_a   <= '0;
      db_b   <= '0;
    end else begin
      sync_a <= {sync_a[0], IA};
      sync_b <= {sync_b[0], IB};
      if (!sync_a[1])          db_a <= '0;
      else if (db_a != DB_MAX) db_a <= db_a + DB_W'(1);
      if (!sync_b[1])          db_b <= '0;
      else if (db_b != DB_MAX) db_b <= db_b + DB_W'(1);
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    enA     = 1'b0;
    enB     = 1'b0;
    oc      = 1'b0;
    lockout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_req) state_d = S_RUN;
      end
      S_RUN: begin
        enA = 1'b1;
        enB = 1'b1;
        if (conf_a || conf_b) state_d = S_TRIP;
        else if (!run_req)    state_d = S_IDLE;
      end
      S_TRIP: begin
        oc      = 1'b1;
        state_d = (retry_inc == RETRY_MAX) ? S_LOCKOUT : S_COOLDOWN;
      end
      S_COOLDOWN: begin
        oc = 1'b1;
        if (timer == TIMER_LAST) state_d = run_req ? S_RUN : S_IDLE;
      end
      S_LOCKOUT: begin
        oc      = 1'b1;
        lockout = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One timer serves both the cooldown and the RUN clean-run window.
  always_ff @(posedge clock) begin
    if (resetBTN) begin
      state_q   <= S_IDLE;
      timer     <= '0;
      trip_src  <= '0;
      fault_src <= '0;
      retry_cnt <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_RUN: begin
          trip_src <= {conf_b, conf_a};
          if (state_d != S_RUN)      timer     <= '0;
          else if (timer == TIMER_LAST) retry_cnt <= '0;
          else                       timer     <= timer + CNT_W'(1);
        end
        S_TRIP: begin
          // Union with the trip-edge snapshot keeps a channel that released during TRIP.
          fault_src <= trip_src | {conf_b, conf_a};
          retry_cnt <= retry_inc;
          timer     <= '0;
        end
        S_COOLDOWN: begin
          timer <= (timer == TIMER_LAST) ? '0 : timer + CNT_W'(1);
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_oc_retry_ctrl.sv
// Directed-vector bench for oc_retry_ctrl with DEBOUNCE=4, COOLDOWN=20, MAX_RETRY=2.
module tb_oc_retry_ctrl;

  logic       clock = 1'b0;
  logic       resetBTN = 1'b1;
  logic       IA = 1'b0;
  logic       IB = 1'b0;
  logic       run_req = 1'b0;
  logic       enA, enB, oc, lockout;
  logic [1:0] fault_src, retry_cnt;

  int n_vec = 0;
  int n_bad = 0;

  oc_retry_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(20),
    .MAX_RETRY      (2),
    .CNT_W          (16)
  ) dut (
    .clock    (clock),
    .resetBTN (resetBTN),
    .IA       (IA),
    .IB       (IB),
    .run_req  (run_req),
    .enA      (enA),
    .enB      (enB),
    .oc       (oc),
    .lockout  (lockout),
    .fault_src(fault_src),
    .retry_cnt(retry_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst, run, ia, ib;
    int         cycles;
    logic [7:0] exp;   // {enA, enB, oc, lockout, fault_src, retry_cnt}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit r, input bit run, input bit a, input bit b,
                     input int cyc, input bit en, input bit o, input bit lk,
                     input bit [1:0] fs, input bit [1:0] rc);
    vec_t v;
    v.name = n; v.rst = r; v.run = run; v.ia = a; v.ib = b; v.cycles = cyc;
    v.exp  = {en, en, o, lk, fs, rc};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {enA, enB, oc, lockout, fault_src, retry_cnt};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {enA,enB,oc,lock,src,rc}=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    int n;
    //   name              rst run ia ib cyc  en oc lk src   rc
    add("reset",            1, 0, 0, 0,   2,  0, 0, 0, 2'b00, 2'd0);
    add("run_1edge",        0, 1, 0, 0,   1,  1, 0, 0, 2'b00, 2'd0);
    add("glitch_ia3",       0, 1, 1, 0,   3,  1, 0, 0, 2'b00, 2'd0);
    add("glitch_after",     0, 1, 0, 0,  10,  1, 0, 0, 2'b00, 2'd0);
    add("ia_pre_trip",      0, 1, 1, 0,   6,  1, 0, 0, 2'b00, 2'd0);
    add("ia_trip_edge",     0, 1, 1, 0,   1,  0, 1, 0, 2'b00, 2'd0);
    add("ia_cool_enter",    0, 1, 1, 0,   1,  0, 1, 0, 2'b01, 2'd1);
    add("ia_cool_hold",     0, 1, 1, 0,   2,  0, 1, 0, 2'b01, 2'd1);
    add("ia_cool_mid",      0, 1, 0, 0,  16,  0, 1, 0, 2'b01, 2'd1);
    add("ia_cool_last",     0, 1, 0, 0,   1,  0, 1, 0, 2'b01, 2'd1);
    add("ia_rerun",         0, 1, 0, 0,   1,  1, 0, 0, 2'b01, 2'd1);
    add("clean_19",         0, 1, 0, 0,  19,  1, 0, 0, 2'b01, 2'd1);
    add("clean_20",         0, 1, 0, 0,   1,  1, 0, 0, 2'b01, 2'd0);
    add("ib_pre_trip",      0, 1, 0, 1,   6,  1, 0, 0, 2'b01, 2'd0);
    add("ib_trip1",         0, 1, 0, 1,   1,  0, 1, 0, 2'b01, 2'd0);
    add("ib_cool1",         0, 1, 0, 1,   1,  0, 1, 0, 2'b10, 2'd1);
    add("ib_cool1_end",     0, 1, 0, 1,  19,  0, 1, 0, 2'b10, 2'd1);
    add("ib_rerun",         0, 1, 0, 1,   1,  1, 0, 0, 2'b10, 2'd1);
    add("ib_trip2",         0, 1, 0, 1,   1,  0, 1, 0, 2'b10, 2'd1);
    add("ib_lockout",       0, 1, 0, 1,   1,  0, 1, 1, 2'b10, 2'd2);
    add("lockout_hold",     0, 1, 0, 1, 100,  0, 1, 1, 2'b10, 2'd2);
    add("lockout_reset",    1, 1, 0, 1,   1,  0, 0, 0, 2'b00, 2'd0);
    add("post_reset_idle",  0, 0, 0, 0,   3,  0, 0, 0, 2'b00, 2'd0);
    add("run_again",        0, 1, 0, 0,   1,  1, 0, 0, 2'b00, 2'd0);
    add("ab_pre_trip",      0, 1, 1, 1,   6,  1, 0, 0, 2'b00, 2'd0);
    add("ab_trip",          0, 1, 0, 0,   1,  0, 1, 0, 2'b00, 2'd0);
    add("ab_cool",          0, 1, 0, 0,   1,  0, 1, 0, 2'b11, 2'd1);
    add("ab_rerun",         0, 1, 0, 0,  20,  1, 0, 0, 2'b11, 2'd1);
    add("ab_clean_19",      0, 1, 0, 0,  19,  1, 0, 0, 2'b11, 2'd1);
    add("ab_clean_20",      0, 1, 0, 0,   1,  1, 0, 0, 2'b11, 2'd0);
    add("rc_trip",          0, 1, 1, 0,   7,  0, 1, 0, 2'b11, 2'd0);
    add("rc_cool",          0, 1, 0, 0,   1,  0, 1, 0, 2'b01, 2'd1);
    add("rc_cool_c10",      0, 1, 0, 0,   9,  0, 1, 0, 2'b01, 2'd1);
    add("rc_reset",         1, 1, 0, 0,   1,  0, 0, 0, 2'b00, 2'd0);
    add("rc_release_run",   0, 1, 0, 0,   1,  1, 0, 0, 2'b00, 2'd0);
    add("run_drop_idle",    0, 0, 0, 0,   1,  0, 0, 0, 2'b00, 2'd0);

    tick();
    foreach (vecs[i]) begin
      resetBTN = vecs[i].rst;
      run_req  = vecs[i].run;
      IA       = vecs[i].ia;
      IB       = vecs[i].ib;
      repeat (vecs[i].cycles) tick();
      check(vecs[i].name, obs(), vecs[i].exp);
    end

    // IB glitch of DEBOUNCE-1 cycles: enables must never drop on any cycle.
    run_req = 1'b1;
    tick();
    IB = 1'b1;
    repeat (3) tick();
    IB = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("ib_glitch_c%0d", k), obs(), {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'd0});
    end

    // Trip latency from first sampled high to enables low, bounded wait.
    IA = 1'b1;
    n  = 0;
    while (enA && n < 20) begin
      tick();
      n++;
    end
    check("trip_latency", 8'(n), 8'd7);
    check("trip_state", obs(), {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0});
    tick();
    check("trip_exit", obs(), {1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'd1});

    resetBTN = 1'b1;
    IA       = 1'b0;
    tick();
    check("final_reset", obs(), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
